// File: rtl/score_window_3x3_if.sv
// score_window_3x3_if: pixel-stream interface of the 3x3 score window.
//   Inputs to the window (driven by the master):
//     ce           pixel accept strobe
//     sof          start of frame, qualified by ce
//     score_in     34-bit unsigned corner score of the accepted pixel
//     iscorner_in  corner-candidate flag of the accepted pixel
//   Outputs of the window (driven by the slave):
//     win11..win33 3x3 score window, row R (1=top), column C (1=left)
//     iscorner_out centre candidate flag gated by border validity
//     x_coord_out  window-centre column, y_coord_out window-centre row
//     win_valid    one-cycle pulse after each accepted pixel
interface score_window_3x3_if;
    logic        ce;
    logic        sof;
    logic [33:0] score_in;
    logic        iscorner_in;
    logic [33:0] win11, win12, win13;
    logic [33:0] win21, win22, win23;
    logic [33:0] win31, win32, win33;
    logic        iscorner_out;
    logic [9:0]  x_coord_out;
    logic [9:0]  y_coord_out;
    logic        win_valid;

    modport master (
        output ce, sof, score_in, iscorner_in,
        input  win11, win12, win13, win21, win22, win23, win31, win32, win33,
        input  iscorner_out, x_coord_out, y_coord_out, win_valid
    );

    modport slave (
        input  ce, sof, score_in, iscorner_in,
        output win11, win12, win13, win21, win22, win23, win31, win32, win33,
        output iscorner_out, x_coord_out, y_coord_out, win_valid
    );
endinterface

// File: rtl/score_window_3x3.sv
// score_window_3x3: builds a 3x3 window of corner scores from a raster pixel stream.
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset (line buffers are not reset)
//   bus  score_window_3x3_if.slave: ce/sof/score_in/iscorner_in in,
//        win11..win33, iscorner_out, x_coord_out, y_coord_out, win_valid out
module score_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input logic                clk,
    input logic                rst,
    score_window_3x3_if.slave  bus
);
    localparam int AW = $clog2(IMG_W);

    logic [9:0]    r_x, r_y;
    logic [34:0]   r_lb1 [IMG_W];
    logic [34:0]   r_lb2 [IMG_W];
    logic [33:0]   r_w11, r_w12, r_w13;
    logic [33:0]   r_w21, r_w22, r_w23;
    logic [33:0]   r_w31, r_w32, r_w33;
    logic          r_c23;
    logic          r_iscorner;
    logic [9:0]    r_xo, r_yo;
    logic          r_valid;

    logic [9:0]    w_px, w_py, w_nx, w_ny;
    logic          w_eol;
    logic [AW-1:0] w_addr;
    logic [34:0]   w_lb1, w_lb2;

    // Position of the pixel being accepted: sof overrides the running counters.
    always_comb begin
        w_px   = bus.sof ? 10'd0 : r_x;
        w_py   = bus.sof ? 10'd0 : r_y;
        w_addr = w_px[AW-1:0];
        w_lb1  = r_lb1[w_addr];
        w_lb2  = r_lb2[w_addr];
        w_eol  = w_px == 10'(IMG_W - 1);
        w_nx   = w_eol ? 10'd0 : w_px + 10'd1;
        w_ny   = !w_eol ? w_py : (w_py == 10'(IMG_H - 1) ? 10'd0 : w_py + 10'd1);
    end

    // Line buffers: LB1 holds row y-1, LB2 holds row y-2, both read before write.
    always_ff @(posedge clk) begin
        if (bus.ce) begin
            r_lb2[w_addr] <= w_lb1;
            r_lb1[w_addr] <= {bus.iscorner_in, bus.score_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_w11      <= '0;
            r_w12      <= '0;
            r_w13      <= '0;
            r_w21      <= '0;
            r_w22      <= '0;
            r_w23      <= '0;
            r_w31      <= '0;
            r_w32      <= '0;
            r_w33      <= '0;
            r_c23      <= 1'b0;
            r_iscorner <= 1'b0;
            r_xo       <= '0;
            r_yo       <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= bus.ce;
            if (bus.ce) begin
                r_x   <= w_nx;
                r_y   <= w_ny;
                r_w11 <= r_w12;
                r_w12 <= r_w13;
                r_w13 <= w_lb2[33:0];
                r_w21 <= r_w22;
                r_w22 <= r_w23;
                r_w23 <= w_lb1[33:0];
                r_w31 <= r_w32;
                r_w32 <= r_w33;
                r_w33 <= bus.score_in;
                // The current mid-right flag becomes the centre flag after this shift.
                r_c23      <= w_lb1[34];
                r_iscorner <= r_c23 && (w_px >= 10'd2) && (w_py >= 10'd2);
                r_xo       <= w_px - 10'd1;
                r_yo       <= w_py - 10'd1;
            end
        end
    end

    assign bus.win11        = r_w11;
    assign bus.win12        = r_w12;
    assign bus.win13        = r_w13;
    assign bus.win21        = r_w21;
    assign bus.win22        = r_w22;
    assign bus.win23        = r_w23;
    assign bus.win31        = r_w31;
    assign bus.win32        = r_w32;
    assign bus.win33        = r_w33;
    assign bus.iscorner_out = r_iscorner;
    assign bus.x_coord_out  = r_xo;
    assign bus.y_coord_out  = r_yo;
    assign bus.win_valid    = r_valid;
endmodule

// File: tb/tb_score_window_3x3.sv
// tb_score_window_3x3: scoreboard bench for score_window_3x3 at IMG_W=8, IMG_H=6.
module tb_score_window_3x3;
    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        logic [8:0][33:0] w;
        logic             ic;
        logic [9:0]       xo;
        logic [9:0]       yo;
        logic             chk_win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    score_window_3x3_if bus();
    score_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t             sb[$];
    logic [33:0]      m_s [H][W];
    logic             m_f [H][W];
    int               bx, by, lx, ly;
    int               n_tests, n_fail, n_ic, n_vp;
    logic [8:0][33:0] prev_w;
    logic [9:0]       prev_xo, prev_yo;
    logic             prev_ic;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0][33:0] cur_win();
        return {bus.win33, bus.win32, bus.win31, bus.win23, bus.win22, bus.win21,
                bus.win13, bus.win12, bus.win11};
    endfunction

    task automatic snap();
        prev_w  = cur_win();
        prev_xo = bus.x_coord_out;
        prev_yo = bus.y_coord_out;
        prev_ic = bus.iscorner_out;
    endtask

    task automatic drive(input logic c, input logic s, input logic [33:0] sc, input logic f);
        exp_t             e;
        logic [8:0][33:0] g;
        int               px, py;
        bus.ce = c;
        bus.sof = s;
        bus.score_in = sc;
        bus.iscorner_in = f;
        if (c) begin
            px = s ? 0 : bx;
            py = s ? 0 : by;
            m_s[py][px] = sc;
            m_f[py][px] = f;
            e.chk_win = px >= 2 && py >= 2;
            e.ic = 1'b0;
            e.w = '0;
            if (e.chk_win) begin
                e.ic = m_f[py-1][px-1];
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        e.w[r*3+k] = m_s[py-2+r][px-2+k];
            end
            e.xo = 10'(px - 1);
            e.yo = 10'(py - 1);
            sb.push_back(e);
            lx = px;
            ly = py;
            bx = (px == W-1) ? 0 : px + 1;
            by = (px == W-1) ? ((py == H-1) ? 0 : py + 1) : py;
        end
        @(posedge clk);
        #1;
        g = cur_win();
        chk("valid", bus.win_valid, c);
        if (c) begin
            e = sb.pop_front();
            chk("xo", bus.x_coord_out, e.xo);
            chk("yo", bus.y_coord_out, e.yo);
            chk("ic", bus.iscorner_out, e.ic);
            if (e.chk_win)
                for (int i = 0; i < 9; i++) chk($sformatf("win%0d", i), g[i], e.w[i]);
            n_ic += int'(bus.iscorner_out);
        end else begin
            chk("hold_xo", bus.x_coord_out, prev_xo);
            chk("hold_yo", bus.y_coord_out, prev_yo);
            chk("hold_ic", bus.iscorner_out, prev_ic);
            for (int i = 0; i < 9; i++) chk($sformatf("hold_win%0d", i), g[i], prev_w[i]);
        end
        n_vp += int'(bus.win_valid);
        snap();
    endtask

    task automatic chk_zero(input string tag);
        logic [8:0][33:0] g;
        g = cur_win();
        chk({tag, "_valid"}, bus.win_valid, 0);
        chk({tag, "_xo"}, bus.x_coord_out, 0);
        chk({tag, "_yo"}, bus.y_coord_out, 0);
        chk({tag, "_ic"}, bus.iscorner_out, 0);
        for (int i = 0; i < 9; i++) chk($sformatf("%s_win%0d", tag, i), g[i], 0);
    endtask

    function automatic logic [33:0] rnd34();
        return {2'($urandom_range(3)), 32'($urandom)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0][33:0] g;
        bus.ce = 1'b0;
        bus.sof = 1'b0;
        bus.score_in = '0;
        bus.iscorner_in = 1'b0;
        bx = 0;
        by = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        snap();

        // Two back-to-back frames of score 8y+x, every pixel a candidate.
        for (int fr = 0; fr < 2; fr++) begin
            n_ic = 0;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    drive(1'b1, fr == 0 && x == 0 && y == 0, 34'(8*y + x), 1'b1);
                    g = cur_win();
                    if (x == 0 && y == 0 && fr == 1) begin
                        chk("wrap_xo", bus.x_coord_out, 10'd1023);
                        chk("wrap_yo", bus.y_coord_out, 10'd1023);
                    end
                    if (x == 3 && y == 2) begin
                        chk("p32_xo", bus.x_coord_out, 2);
                        chk("p32_yo", bus.y_coord_out, 1);
                        chk("p32_w11", g[0], 1);
                        chk("p32_w22", g[4], 10);
                        chk("p32_w33", g[8], 19);
                    end
                    if (x == 4 && y == 2) begin
                        for (int i = 0; i < 9; i++)
                            chk($sformatf("p42_win%0d", i), g[i], 2 + 8*(i/3) + (i%3));
                        chk("p42_xo", bus.x_coord_out, 3);
                    end
                end
            chk("ic_count", n_ic, 24);
        end

        // Alternate ce with junk (including sof) on idle cycles.
        n_vp = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                drive(1'b1, 1'b0, 34'(8*y + x), 1'(x + y));
                drive(1'b0, 1'b1, rnd34(), 1'b1);
            end
        chk("vp_count", n_vp, 48);

        // Random frame abandoned by sof at (5,3), then a full new frame.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (!(y > 3 || (y == 3 && x > 5)))
                    drive(1'b1, y == 3 && x == 5, rnd34(), 1'b1);
        chk("sof_xo", bus.x_coord_out, 10'd1023);
        chk("sof_yo", bus.y_coord_out, 10'd1023);
        chk("sof_ic", bus.iscorner_out, 0);
        for (int i = 1; i < W*H; i++) drive(1'b1, 1'b0, rnd34(), 1'($urandom_range(1)));

        // Asynchronous reset mid-line, between clock edges.
        for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, rnd34(), 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("arst");
        #2;
        rst = 1'b0;
        bx = 0;
        by = 0;
        sb.delete();
        snap();
        drive(1'b1, 1'b0, 34'h2_0000_0001, 1'b1);
        chk("arst_xo", bus.x_coord_out, 10'd1023);
        chk("arst_yo", bus.y_coord_out, 10'd1023);
        chk("arst_ic", bus.iscorner_out, 0);
        for (int i = 1; i < W*H; i++) drive(1'b1, 1'b0, rnd34(), 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
